servo_pwm: RTL and testbench
============================

# servo_pwm

Servo PWM generator downstream of the periodic `pulse` strobe generator. It consumes that block's multi-cycle tick window as a timebase, edge-detecting it to one event per tick. It produces a fixed-period servo frame whose high time is set by a position command. Commands arrive over a valid/ready handshake and take effect only at frame boundaries, so a pulse is never glitched mid-frame.

## Interface
- `PERIOD_TICKS`, 20000: ticks per frame; must be > `MAX_WIDTH`.
- `MIN_WIDTH`, 1000: high time in ticks for command 0.
- `MAX_WIDTH`, 2000: maximum high time in ticks.
- `CMD_W`, 11: command width in bits.
- `clock` input 1: single clock domain.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: run request.
- `tick` input 1: timebase strobe; may stay high several cycles per tick.
- `cmd` input `CMD_W`: unsigned position offset above `MIN_WIDTH`.
- `cmd_valid` input 1: `cmd` is valid.
- `cmd_ready` output 1: pending slot is empty.
- `pwm` output 1: servo drive, registered.
- `frame_start` output 1: one-cycle pulse at every frame boundary while running.
- `clamp_event` output 1: one-cycle pulse when an accepted `cmd` was clamped.

## Operation
- Tick event: `tick & ~tick_q`. `tick_q` is registered every cycle in all states, including under reset (cleared to 0).
- Width is `MIN_WIDTH + min(cmd, MAX_WIDTH-MIN_WIDTH)`, computed at accept time into the pending register. The tick counter and width registers are 16 bits and compare unsigned.
- Handshake:
  - `cmd_ready = ~pending_valid`.
  - Accept on `cmd_valid & cmd_ready`.
  - `clamp_event` pulses the cycle after an accept whose `cmd` exceeded `MAX_WIDTH-MIN_WIDTH`.
- Frame boundary occurs in either case:
  - on a tick event in RUN when `tick_count == PERIOD_TICKS-1`;
  - on the IDLE→RUN entry.
  - At a boundary: `tick_count`←0, `frame_start`←1, and if `pending_valid` then `active_width`←pending and `pending_valid`←0.
- Otherwise a tick event in RUN increments `tick_count`.
- FSM:
  - IDLE: `pwm` 0, `tick_count` held at 0. Go to RUN when `enable`=1, performing a boundary.
  - RUN: `pwm` ← (`tick_count_next < active_width`). On `enable`=0: go to DRAIN if `pwm` is currently 1, else go to IDLE.
  - DRAIN: keep counting ticks; `pwm` stays 1 until `tick_count_next >= active_width`, then `pwm`←0 and go to IDLE. `enable` is ignored in DRAIN; re-entry is only from IDLE. No `frame_start` in DRAIN.
- Simultaneous accept and boundary in the same cycle: the boundary uses the old pending contents (empty → `active_width` unchanged). The new command lands in pending for the next boundary.
- Accepts are allowed in every state.

## Timing
- Reset values:
  - state IDLE, `tick_count` 0, `tick_q` 0;
  - `pwm` 0, `frame_start` 0, `clamp_event` 0;
  - `pending_valid` 0, so `cmd_ready` 1;
  - `active_width` = (`MIN_WIDTH+MAX_WIDTH`)/2.
- Reset mid-frame: `pwm` low the next cycle; the pending command is discarded.
- Tick event detected in cycle n: `tick_count`, `pwm` and `frame_start` are updated at the edge ending cycle n and are visible in cycle n+1.
- Frame length is exactly `PERIOD_TICKS` tick events. The high phase is exactly `active_width` tick events, starting at the boundary.
- `cmd_ready` falls the cycle after accept and rises the cycle after the boundary that consumes the pending command.
- `tick` held high for many cycles counts once. `tick` high already on the first cycle after reset counts as an event.

## Structure
- Package `servo_pkg`:
  - state enum {IDLE, RUN, DRAIN};
  - default `PERIOD_TICKS`/`MIN_WIDTH`/`MAX_WIDTH`;
  - the 16-bit counter width constant.
- Sub-module `tick_edge`: registered rising-edge detector (`clock`, `reset`, `in`, `rise`), reusable for other `pulse` consumers.
- Everything else (FSM, counter, pending/active registers, clamp) lives in `servo_pwm`.

## Test plan
Bench parameters: `PERIOD_TICKS`=20, `MIN_WIDTH`=2, `MAX_WIDTH`=6, with `tick` driven as 9-cycle-high windows every 30 cycles.
1. Reset then `enable`=1 with no command → `frame_start` pulses once per 20 tick events; `pwm` high for exactly 4 tick events per frame.
2. Accept `cmd`=3 mid-frame → `cmd_ready`=0 next cycle; current frame keeps width 4; next frame `pwm` is high 5 ticks; `cmd_ready` returns to 1 after that boundary.
3. `cmd`=50 → `clamp_event` pulses once; subsequent frames are high 6 ticks.
4. Accept asserted in the same cycle as the boundary tick → that frame keeps the old width; the following frame uses the new width.
5. Drop `enable` at tick 1 of a 4-tick high phase → `pwm` stays high through tick 3, then IDLE with `pwm` 0 and `tick_count` 0. Dropping `enable` in the low phase → IDLE in one cycle.
6. Assert `reset` while `pwm`=1 with a command pending → `pwm` 0 next cycle, `cmd_ready` 1, width back to 4 on re-enable.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: shared types and constants for the servo PWM generator.
//   - state_t      : servo FSM state encoding
//   - CNT_W        : width of the tick counter and pulse-width registers
//   - DEF_*        : default frame/pulse geometry and command width
//   - clamp_width(): MIN + min(cmd, span), all unsigned CNT_W arithmetic
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CNT_W            = 16;
  localparam int DEF_PERIOD_TICKS = 20000;
  localparam int DEF_MIN_WIDTH    = 1000;
  localparam int DEF_MAX_WIDTH    = 2000;
  localparam int DEF_CMD_W        = 11;

  // High time for a command: offset above the minimum, saturated at the span.
  function automatic logic [CNT_W-1:0] clamp_width(
    input logic [CNT_W-1:0] cmd_ext,
    input logic [CNT_W-1:0] min_w,
    input logic [CNT_W-1:0] span_w
  );
    return min_w + ((cmd_ext > span_w) ? span_w : cmd_ext);
  endfunction

endpackage

// File: rtl/tick_edge.sv
// tick_edge: registered rising-edge detector for multi-cycle strobes such as
// the pulse block's tick window. One rise per low-to-high transition.
// Ports:
//   clock : clock
//   reset : synchronous active-high reset (clears the history bit)
//   in    : level input
//   rise  : in & ~in_delayed; high in the first cycle in is seen high
module tick_edge (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q_r;

  // History bit; cleared in reset so a level already high afterwards still
  // produces an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q_r <= 1'b0;
    end else begin
      in_q_r <= in;
    end
  end

  assign rise = in & ~in_q_r;

endmodule

// File: rtl/servo_pwm.sv
// servo_pwm: fixed-period servo frame generator driven by a tick timebase.
// The high time comes from a position command taken over valid/ready into a
// one-deep pending slot, and only moves into the active width at a frame
// boundary so a pulse is never altered mid-frame.
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   enable             : run request (ignored while draining a pulse)
//   tick               : timebase window, edge-detected to one event per tick
//   cmd, cmd_valid     : position offset above MIN_WIDTH and its valid
//   cmd_ready          : pending slot empty
//   pwm                : registered servo drive
//   frame_start        : one-cycle strobe at each frame boundary
//   clamp_event        : one-cycle strobe after accepting an out-of-range cmd
module servo_pwm
  import servo_pkg::*;
#(
  parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int MIN_WIDTH    = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH    = DEF_MAX_WIDTH,
  parameter int CMD_W        = DEF_CMD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             pwm,
  output logic             frame_start,
  output logic             clamp_event
);

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_W     = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] SPAN_W    = CNT_W'(MAX_WIDTH - MIN_WIDTH);
  localparam logic [CNT_W-1:0] RESET_W   = CNT_W'((MIN_WIDTH + MAX_WIDTH) / 2);
  localparam logic [CNT_W-1:0] ZERO_W    = {CNT_W{1'b0}};

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  count_r, count_s, count_inc_s;
  logic [CNT_W-1:0]  active_r, active_s;
  logic [CNT_W-1:0]  pend_r, pend_s;
  logic              pend_valid_r, pend_valid_s;
  logic              pwm_r, pwm_s;
  logic              frame_start_r, frame_start_s;
  logic              clamp_r, clamp_s;
  logic              tick_ev_s, accept_s, boundary_s;
  logic [CNT_W-1:0]  cmd_ext_s, width_s;

  tick_edge u_tick_edge (
    .clock (clock),
    .reset (reset),
    .in    (tick),
    .rise  (tick_ev_s)
  );

  assign cmd_ext_s   = CNT_W'(cmd);
  assign width_s     = clamp_width(cmd_ext_s, MIN_W, SPAN_W);
  assign accept_s    = cmd_valid & ~pend_valid_r;
  assign clamp_s     = accept_s & (cmd_ext_s > SPAN_W);
  assign count_inc_s = tick_ev_s ? (count_r + CNT_W'(1)) : count_r;

  // Next-state logic: FSM, tick counter, width registers and strobes.
  always_comb begin
    state_s       = state_r;
    count_s       = count_r;
    pwm_s         = 1'b0;
    frame_start_s = 1'b0;
    active_s      = active_r;
    pend_s        = pend_r;
    pend_valid_s  = pend_valid_r;
    boundary_s    = 1'b0;

    case (state_r)
      IDLE: begin
        count_s = ZERO_W;
        if (enable) begin
          state_s    = RUN;
          boundary_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN, DRAIN: begin
        if ((state_r == RUN) && enable) begin
          if (tick_ev_s && (count_r == LAST_TICK)) begin
            boundary_s = 1'b1;
          end else begin
            count_s = count_inc_s;
            pwm_s   = (count_inc_s < active_r);
          end
        end else if (pwm_r) begin
          // Pulse already on the wire: let it run to its full width.
          if (count_inc_s >= active_r) begin
            state_s = IDLE;
            count_s = ZERO_W;
          end else begin
            state_s = DRAIN;
            count_s = count_inc_s;
            pwm_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
          count_s = ZERO_W;
        end
      end
      default: begin
        state_s = IDLE;
        count_s = ZERO_W;
      end
    endcase

    // Boundary consumes only what was pending before this cycle; a command
    // accepted now waits for the next boundary.
    if (boundary_s) begin
      count_s       = ZERO_W;
      frame_start_s = 1'b1;
      if (pend_valid_r) begin
        active_s     = pend_r;
        pend_valid_s = 1'b0;
      end else begin
        active_s = active_r;
      end
      pwm_s = (ZERO_W < active_s);
    end else begin
      frame_start_s = 1'b0;
    end

    if (accept_s) begin
      pend_s       = width_s;
      pend_valid_s = 1'b1;
    end else begin
      pend_s = pend_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      count_r       <= ZERO_W;
      active_r      <= RESET_W;
      pend_r        <= ZERO_W;
      pend_valid_r  <= 1'b0;
      pwm_r         <= 1'b0;
      frame_start_r <= 1'b0;
      clamp_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      count_r       <= count_s;
      active_r      <= active_s;
      pend_r        <= pend_s;
      pend_valid_r  <= pend_valid_s;
      pwm_r         <= pwm_s;
      frame_start_r <= frame_start_s;
      clamp_r       <= clamp_s;
    end
  end

  assign cmd_ready   = ~pend_valid_r;
  assign pwm         = pwm_r;
  assign frame_start = frame_start_r;
  assign clamp_event = clamp_r;

endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: self-checking bench for servo_pwm with a small geometry
// (20 ticks per frame, widths 2..6, tick = 9-cycle window every 30 cycles).
// A monitor measures every frame length and every pwm pulse in tick events
// and compares pulse widths against a scoreboard queue fed at frame starts.
module tb_servo_pwm;

  localparam int PERIOD = 20;
  localparam int MINW   = 2;
  localparam int MAXW   = 6;
  localparam int CW     = 11;
  localparam int MIDW   = 4;
  localparam int NV     = 7;

  logic          clock, reset, enable, tick, cmd_valid;
  logic [CW-1:0] cmd;
  logic          cmd_ready, pwm, frame_start, clamp_event;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected pulse widths, one per frame start.
  int exp_q[$];

  // Bench-side width bookkeeping.
  int m_active     = MIDW;
  int m_pend       = 0;
  int m_acc_cyc    = 0;
  bit m_pend_valid = 1'b0;

  // Monitor state.
  bit mon_tq       = 1'b0;
  bit mon_in_frame = 1'b0;
  bit mon_in_pulse = 1'b0;
  bit mon_skip     = 1'b0;
  int mon_fticks   = 0;
  int mon_hticks   = 0;

  typedef struct {
    int cmd;
    int clamp;
    int width;
  } vec_t;
  vec_t vecs[NV];

  servo_pwm #(
    .PERIOD_TICKS (PERIOD),
    .MIN_WIDTH    (MINW),
    .MAX_WIDTH    (MAXW),
    .CMD_W        (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .pwm         (pwm),
    .frame_start (frame_start),
    .clamp_event (clamp_event)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Tick timebase: high for 9 cycles out of every 30.
  initial begin
    int ph;
    ph   = 0;
    tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tick = (ph < 9);
      ph   = (ph + 1) % 30;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_start && n < 1300);
    chk("frame_start_seen", frame_start, 1);
  endtask

  task automatic send_cmd(input int c, input int w);
    @(posedge clock);
    #1;
    cmd          = CW'(c);
    cmd_valid    = 1'b1;
    m_pend       = w;
    m_pend_valid = 1'b1;
    m_acc_cyc    = cyc;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Monitor: frame length and pulse width in tick events, scoreboard compare.
  initial begin
    bit tev;
    int w;
    forever begin
      @(negedge clock);
      tev = tick & ~mon_tq;
      if (reset || !enable) mon_in_frame = 1'b0;
      if (reset && pwm) mon_skip = 1'b1;
      if (frame_start) begin
        if (mon_in_frame) chk("frame_len", mon_fticks, PERIOD);
        mon_in_frame = 1'b1;
        mon_fticks   = 0;
        if (m_pend_valid && (m_acc_cyc < cyc - 1)) begin
          m_active     = m_pend;
          m_pend_valid = 1'b0;
        end
        exp_q.push_back(m_active);
      end
      if (tev) mon_fticks++;
      if (pwm) begin
        mon_in_pulse = 1'b1;
        if (tev) mon_hticks++;
      end else if (mon_in_pulse) begin
        mon_in_pulse = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got pulse of %0d ticks expected none", mon_hticks);
        end else begin
          w = exp_q.pop_front();
          if (!mon_skip) chk("pulse_width", mon_hticks, w);
        end
        mon_skip   = 1'b0;
        mon_hticks = 0;
      end
      mon_tq = reset ? 1'b0 : tick;
    end
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    cmd       = '0;
    cmd_valid = 1'b0;

    vecs[0] = '{3,    0, 5};
    vecs[1] = '{50,   1, 6};
    vecs[2] = '{4,    0, 6};
    vecs[3] = '{5,    1, 6};
    vecs[4] = '{2047, 1, 6};
    vecs[5] = '{0,    0, 2};
    vecs[6] = '{1,    0, 3};

    // Reset values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_pwm", pwm, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_clamp", clamp_event, 0);
    chk("rst_ready", cmd_ready, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Enable with no command: immediate boundary, default width.
    @(posedge clock);
    #1;
    enable = 1'b1;
    @(negedge clock);
    chk("idle_pwm", pwm, 0);
    @(negedge clock);
    chk("entry_frame_start", frame_start, 1);
    chk("entry_pwm", pwm, 1);
    @(negedge clock);
    chk("frame_start_one_cycle", frame_start, 0);
    repeat (3) wait_fs();

    // Command table: accept mid-pulse, width changes at the next frame.
    for (int i = 0; i < NV; i++) begin
      repeat (100) @(negedge clock);
      chk("ready_before_accept", cmd_ready, 1);
      send_cmd(vecs[i].cmd, vecs[i].width);
      @(negedge clock);
      chk("ready_after_accept", cmd_ready, 0);
      chk("clamp_event", clamp_event, vecs[i].clamp);
      @(negedge clock);
      chk("clamp_one_cycle", clamp_event, 0);
      wait_fs();
      chk("ready_after_boundary", cmd_ready, 1);
    end

    // Accept in the same cycle as the boundary tick (600 cycles per frame).
    repeat (599) @(posedge clock);
    #1;
    cmd          = CW'(2);
    cmd_valid    = 1'b1;
    m_pend       = 4;
    m_pend_valid = 1'b1;
    m_acc_cyc    = cyc;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    chk("bnd_accept_frame_start", frame_start, 1);
    chk("bnd_accept_ready", cmd_ready, 0);
    wait_fs();
    chk("bnd_accept_ready_back", cmd_ready, 1);

    // Drain: drop enable at count 1 of a 4-tick pulse, re-raise during drain.
    repeat (40) @(posedge clock);
    #1;
    enable = 1'b0;
    repeat (50) @(posedge clock);
    #1;
    enable = 1'b1;
    repeat (29) @(posedge clock);
    @(negedge clock);
    chk("drain_high_tick3", pwm, 1);
    @(negedge clock);
    chk("drain_end_pwm", pwm, 0);
    chk("drain_no_frame_start", frame_start, 0);
    @(negedge clock);
    chk("reentry_frame_start", frame_start, 1);
    chk("reentry_pwm", pwm, 1);

    // Drop enable for one cycle in the low phase.
    repeat (180) @(negedge clock);
    chk("low_phase_pwm", pwm, 0);
    @(posedge clock);
    #1;
    enable = 1'b0;
    @(posedge clock);
    #1;
    enable = 1'b1;
    @(negedge clock);
    chk("low_drop_idle_fs", frame_start, 0);
    @(negedge clock);
    chk("low_drop_reentry_fs", frame_start, 1);

    // Reset mid-pulse with a command pending; active width is 6 at the time.
    send_cmd(4, 6);
    wait_fs();
    chk("pre_reset_pwm", pwm, 1);
    repeat (30) @(posedge clock);
    send_cmd(0, 2);
    repeat (20) @(posedge clock);
    #1;
    reset        = 1'b1;
    enable       = 1'b0;
    m_pend_valid = 1'b0;
    m_active     = MIDW;
    @(negedge clock);
    @(negedge clock);
    chk("reset_mid_pwm", pwm, 0);
    chk("reset_mid_ready", cmd_ready, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    enable = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("post_reset_frame_start", frame_start, 1);
    repeat (200) @(negedge clock);
    chk("post_reset_low", pwm, 0);
    @(posedge clock);
    #1;
    enable = 1'b0;
    repeat (5) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
